// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: shared state, class, opcode and control-word definitions for the multi-cycle sequencer
package rv32i_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_NOP} class_e;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  typedef struct packed {
    logic [2:0] imm_sel;
    logic       br_un;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic       reg_wen;
    logic       pc_wen;
    logic       pc_sel;
  } ctrl_t;
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_decode.sv
// rv32i_decode: combinational RV32I decode into the EXEC control word, instruction class and illegal flag
module rv32i_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        br_eq,
  input  logic        br_lt,
  output ctrl_t       cw,
  output class_e      cls,
  output logic        illegal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       alt;
  logic       taken;
  assign op  = inst[6:0];
  assign f3  = inst[14:12];
  assign alt = inst[30];
  // f3[0] inverts the sense, f3[2] picks less-than over equality
  assign taken = f3[0] ^ (f3[2] ? br_lt : br_eq);
  always_comb begin
    cw = '0;
    cls = CL_NOP;
    illegal = 1'b0;
    case (op)
      OPC_OP: begin
        cls = CL_ALU;
        cw.alu_sel = alu_f3(f3, alt);
        cw.reg_wen = 1'b1;
        cw.wb_sel = WB_ALU;
        cw.pc_wen = 1'b1;
        illegal = alt && f3 != 3'b000 && f3 != 3'b101;
      end
      OPC_OPIMM: begin
        cls = CL_ALU;
        cw.imm_sel = IMM_I;
        cw.b_sel = 1'b1;
        cw.alu_sel = alu_f3(f3, alt);
        cw.reg_wen = 1'b1;
        cw.wb_sel = WB_ALU;
        cw.pc_wen = 1'b1;
        illegal = alt && f3 != 3'b101;
      end
      OPC_LUI: begin
        cls = CL_ALU;
        cw.imm_sel = IMM_U;
        cw.b_sel = 1'b1;
        cw.alu_sel = ALU_PASSB;
        cw.reg_wen = 1'b1;
        cw.wb_sel = WB_ALU;
        cw.pc_wen = 1'b1;
      end
      OPC_AUIPC: begin
        cls = CL_ALU;
        cw.imm_sel = IMM_U;
        cw.a_sel = 1'b1;
        cw.b_sel = 1'b1;
        cw.reg_wen = 1'b1;
        cw.wb_sel = WB_ALU;
        cw.pc_wen = 1'b1;
      end
      OPC_JAL: begin
        cls = CL_JUMP;
        cw.imm_sel = IMM_J;
        cw.a_sel = 1'b1;
        cw.b_sel = 1'b1;
        cw.reg_wen = 1'b1;
        cw.wb_sel = WB_PC4;
        cw.pc_wen = 1'b1;
        cw.pc_sel = 1'b1;
      end
      OPC_JALR: begin
        cls = CL_JUMP;
        cw.imm_sel = IMM_I;
        cw.b_sel = 1'b1;
        cw.reg_wen = 1'b1;
        cw.wb_sel = WB_PC4;
        cw.pc_wen = 1'b1;
        cw.pc_sel = 1'b1;
        illegal = f3 != 3'b000;
      end
      OPC_BRANCH: begin
        cls = CL_BRANCH;
        cw.imm_sel = IMM_B;
        cw.a_sel = 1'b1;
        cw.b_sel = 1'b1;
        cw.br_un = f3[2] & f3[1];
        cw.pc_wen = 1'b1;
        cw.pc_sel = taken;
        illegal = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        cls = CL_LOAD;
        cw.imm_sel = IMM_I;
        cw.b_sel = 1'b1;
        illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        cls = CL_STORE;
        cw.imm_sel = IMM_S;
        cw.b_sel = 1'b1;
        illegal = f3[2];
      end
      OPC_FENCE: cw.pc_wen = 1'b1;
      default:   illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) illegal = 1'b1;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer sharing one memory port between fetch and load/store
module multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Inst,
  input  logic                  BrEq,
  input  logic                  BrLT,
  input  logic                  MemReady,
  output logic                  MemReq,
  output logic                  AddrSel,
  output logic                  MemRW,
  output logic                  IRWEn,
  output logic                  PCWEn,
  output logic                  PCSel,
  output logic [2:0]            ImmSel,
  output logic                  RegWEn,
  output logic                  BrUn,
  output logic                  ASel,
  output logic                  BSel,
  output logic [3:0]            ALUSel,
  output logic [1:0]            WBSel,
  output logic                  InstRet,
  output logic                  Halt
);
  state_e state_q, state_d;
  ctrl_t  cw;
  class_e cls;
  logic   illegal;
  logic   is_store;
  rv32i_decode u_decode (
    .inst    (Inst[31:0]),
    .br_eq   (BrEq),
    .br_lt   (BrLT),
    .cw      (cw),
    .cls     (cls),
    .illegal (illegal)
  );
  assign is_store = cls == CL_STORE;
  always_comb begin
    state_d = state_q;
    MemReq = 1'b0;
    AddrSel = 1'b0;
    MemRW = 1'b0;
    IRWEn = 1'b0;
    PCWEn = 1'b0;
    PCSel = 1'b0;
    ImmSel = '0;
    RegWEn = 1'b0;
    BrUn = 1'b0;
    ASel = 1'b0;
    BSel = 1'b0;
    ALUSel = '0;
    WBSel = '0;
    Halt = 1'b0;
    // reset silences every output, abandoning any pending memory request
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemReq = 1'b1;
          IRWEn = MemReady;
          state_d = MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
        S_EXEC: begin
          {ImmSel, BrUn, ASel, BSel, ALUSel, WBSel, RegWEn, PCWEn, PCSel} = cw;
          state_d = (cls == CL_LOAD || is_store) ? S_MEM : S_FETCH;
        end
        S_MEM: begin
          MemReq = 1'b1;
          AddrSel = 1'b1;
          MemRW = is_store;
          ImmSel = cw.imm_sel;
          BSel = 1'b1;
          ALUSel = ALU_ADD;
          PCWEn = MemReady & is_store;
          state_d = MemReady ? (is_store ? S_FETCH : S_WB) : S_MEM;
        end
        S_WB: begin
          RegWEn = 1'b1;
          WBSel = WB_MEM;
          PCWEn = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT:  Halt = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
    InstRet = PCWEn;
  end
  always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;
endmodule
